mure_itype_buffer: RTL

Multi-retire instruction-type classifier and uop buffer between the CPU retire ports and the trace encoder. Accepts up to NRET retired instructions per cycle and classifies each into an itype code (3-bit base set or 4-bit extended call/return set). Packs valid lanes in lane order into a circular buffer of DEPTH entries and drains one entry per cycle over a valid/ready interface.

---
 rtl/mure_itype_buffer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mure_itype_buffer.sv
// mure_itype_buffer: classifies up to NRET retired instructions per cycle into
// trace itype codes and packs the valid lanes, in lane order, into a circular
// buffer that drains one entry per cycle over valid/ready.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   valid_i .. eret_i     per-lane retire payload and event flags
//   cause_i/tval_i/priv_i shared fields copied into every entry pushed that cycle
//   ready_o               at least NRET free entries (registered count only)
//   valid_o / ready_i     head entry handshake
//   pc_o .. priv_o        head entry fields
//   count_o               occupancy
//   overflow_o            sticky: a push cycle was dropped
module mure_itype_buffer #(
    parameter int unsigned NRET      = 2,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned INST_LEN  = 32,
    parameter int unsigned ITYPE_LEN = 3,
    parameter int unsigned CAUSE_LEN = 5,
    parameter int unsigned PRIV_LEN  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NRET-1:0]          valid_i,
    input  logic [NRET*XLEN-1:0]     pc_i,
    input  logic [NRET*INST_LEN-1:0] inst_data_i,
    input  logic [NRET-1:0]          compressed_i,
    input  logic [NRET-1:0]          taken_i,
    input  logic [NRET-1:0]          exception_i,
    input  logic [NRET-1:0]          interrupt_i,
    input  logic [NRET-1:0]          eret_i,
    input  logic [CAUSE_LEN-1:0]     cause_i,
    input  logic [XLEN-1:0]          tval_i,
    input  logic [PRIV_LEN-1:0]      priv_i,
    output logic                     ready_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [XLEN-1:0]          pc_o,
    output logic [INST_LEN-1:0]      inst_data_o,
    output logic [ITYPE_LEN-1:0]     itype_o,
    output logic                     compressed_o,
    output logic                     exception_o,
    output logic                     interrupt_o,
    output logic                     eret_o,
    output logic [CAUSE_LEN-1:0]     cause_o,
    output logic [XLEN-1:0]          tval_o,
    output logic [PRIV_LEN-1:0]      priv_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    // Indirect-jump code from link usage of rd/rs1
    function automatic logic [3:0] jalr_code(input logic [4:0] rd, input logic [4:0] rs1);
        if (ITYPE_LEN == 3)                              return 4'd6;
        if (is_link(rd) && is_link(rs1) && (rd != rs1))  return 4'd12;
        if (is_link(rd))                                 return 4'd8;
        if (is_link(rs1))                                return 4'd13;
        return 4'd14;
    endfunction

    // Per-lane itype classification, first match wins
    function automatic logic [3:0] classify(
        input logic [INST_LEN-1:0] inst,
        input logic c, input logic t, input logic e, input logic irq, input logic er
    );
        logic [31:0] w;
        logic [15:0] h;
        w = 32'(inst);
        h = w[15:0];
        if (e)   return 4'd1;
        if (irq) return 4'd2;
        if (er)  return 4'd3;
        if (!c) begin
            if (w == 32'h3020_0073 || w == 32'h1020_0073 || w == 32'h0020_0073) return 4'd3;
            if (w[6:0] == 7'h63) return t ? 4'd5 : 4'd4;
            if (w[6:0] == 7'h67 && w[14:12] == 3'b000) return jalr_code(w[11:7], w[19:15]);
            if (w[6:0] == 7'h6f) return (ITYPE_LEN == 3) ? 4'd0 : (is_link(w[11:7]) ? 4'd9 : 4'd15);
            return 4'd0;
        end
        if (h[1:0] == 2'b01 && h[15:14] == 2'b11) return t ? 4'd5 : 4'd4;
        if (h[1:0] == 2'b01 && h[15:13] == 3'b101) return (ITYPE_LEN == 3) ? 4'd0 : 4'd15;
        if (h[1:0] == 2'b01 && h[15:13] == 3'b001) return (ITYPE_LEN == 3) ? 4'd0 : 4'd9;
        // C.JR / C.JALR: rs1 != 0 and rs2 == 0; bit 12 selects the linking form
        if (h[1:0] == 2'b10 && h[15:13] == 3'b100 && h[11:7] != 5'd0 && h[6:2] == 5'd0)
            return jalr_code(h[12] ? 5'd1 : 5'd0, h[11:7]);
        return 4'd0;
    endfunction

    logic [XLEN-1:0]      pc_q    [DEPTH];
    logic [INST_LEN-1:0]  inst_q  [DEPTH];
    logic [ITYPE_LEN-1:0] itype_q [DEPTH];
    logic                 comp_q  [DEPTH];
    logic                 exc_q   [DEPTH];
    logic                 irq_q   [DEPTH];
    logic                 eret_q  [DEPTH];
    logic [CAUSE_LEN-1:0] cause_q [DEPTH];
    logic [XLEN-1:0]      tval_q  [DEPTH];
    logic [PRIV_LEN-1:0]  priv_q  [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;

    logic [PW-1:0] lane_slot  [NRET];
    logic [3:0]    lane_itype [NRET];
    logic [CW-1:0] npush;
    logic          push_en, pop;

    // Slot of each lane = wr_ptr + number of valid lanes below it
    always_comb begin
        npush = '0;
        for (int k = 0; k < NRET; k++) begin
            lane_slot[k]  = wr_ptr_q + PW'(npush);
            npush         = npush + CW'(valid_i[k]);
            lane_itype[k] = classify(inst_data_i[k*INST_LEN +: INST_LEN], compressed_i[k],
                                     taken_i[k], exception_i[k], interrupt_i[k], eret_i[k]);
        end
    end

    assign ready_o = (CW'(DEPTH) - count_q) >= CW'(NRET);
    assign valid_o = (count_q != '0);
    assign push_en = (|valid_i) && ready_o;
    assign pop     = valid_o && ready_i;

    // Buffer storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                inst_q[i]  <= '0;
                itype_q[i] <= '0;
                comp_q[i]  <= 1'b0;
                exc_q[i]   <= 1'b0;
                irq_q[i]   <= 1'b0;
                eret_q[i]  <= 1'b0;
                cause_q[i] <= '0;
                tval_q[i]  <= '0;
                priv_q[i]  <= '0;
            end
        end else begin
            if (push_en) begin
                for (int k = 0; k < NRET; k++) begin
                    if (valid_i[k]) begin
                        pc_q[lane_slot[k]]    <= pc_i[k*XLEN +: XLEN];
                        inst_q[lane_slot[k]]  <= inst_data_i[k*INST_LEN +: INST_LEN];
                        itype_q[lane_slot[k]] <= ITYPE_LEN'(lane_itype[k]);
                        comp_q[lane_slot[k]]  <= compressed_i[k];
                        exc_q[lane_slot[k]]   <= exception_i[k];
                        irq_q[lane_slot[k]]   <= interrupt_i[k];
                        eret_q[lane_slot[k]]  <= eret_i[k];
                        cause_q[lane_slot[k]] <= cause_i;
                        tval_q[lane_slot[k]]  <= tval_i;
                        priv_q[lane_slot[k]]  <= priv_i;
                    end
                end
                wr_ptr_q <= wr_ptr_q + PW'(npush);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + (push_en ? npush : CW'(0)) - CW'(pop);
            if ((|valid_i) && !ready_o) overflow_q <= 1'b1;
        end
    end

    assign pc_o         = pc_q[rd_ptr_q];
    assign inst_data_o  = inst_q[rd_ptr_q];
    assign itype_o      = itype_q[rd_ptr_q];
    assign compressed_o = comp_q[rd_ptr_q];
    assign exception_o  = exc_q[rd_ptr_q];
    assign interrupt_o  = irq_q[rd_ptr_q];
    assign eret_o       = eret_q[rd_ptr_q];
    assign cause_o      = cause_q[rd_ptr_q];
    assign tval_o       = tval_q[rd_ptr_q];
    assign priv_o       = priv_q[rd_ptr_q];
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;

endmodule
